// File: rtl/f2h_tester_pkg.sv
// ----------------------------------------------------------------------------
// f2h_tester_pkg
// Shared definitions for the F2H interface tester:
//   - CSR byte offsets (decoded on csr address bits [5:0])
//   - FSM state encoding
//   - STATUS register bit positions
//   - lane_lsb(): converts a 32-bit lane index into the first byte-enable bit
// Optional build macro F2H_TESTER_TIMEOUT_EN (used by the top) is not
// referenced here.
// ----------------------------------------------------------------------------
package f2h_tester_pkg;

   localparam logic [5:0] CSR_CTRL    = 6'h00;
   localparam logic [5:0] CSR_ADDR_LO = 6'h04;
   localparam logic [5:0] CSR_WDATA   = 6'h08;
   localparam logic [5:0] CSR_ADDR_HI = 6'h0C;
   localparam logic [5:0] CSR_STATUS  = 6'h10;
   localparam logic [5:0] CSR_RDATA   = 6'h14;
   localparam logic [5:0] CSR_WR_CNT  = 6'h18;
   localparam logic [5:0] CSR_RD_CNT  = 6'h1C;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_WR_DONE = 1;
   localparam int STAT_RD_DONE = 2;
   localparam int STAT_TIMEOUT = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_REQ  = 2'd1,
      ST_RD_REQ  = 2'd2,
      ST_RD_WAIT = 2'd3
   } state_t;

   // A 32-bit lane covers 4 byte enables; lane n starts at byte 4*n.
   function automatic logic [5:0] lane_lsb(input logic [3:0] lane);
      return {lane, 2'b00};
   endfunction

endpackage

// File: rtl/f2h_tester_if.sv
// ----------------------------------------------------------------------------
// f2h_tester_if
// Avalon-MM bus bundle for the F2H master port.
//   master modport: drives write/read/address/byteenable/writedata,
//                   receives readdatavalid/readdata/waitrequest.
//   slave modport : the mirror image.
// Handshake: a request (write or read high) is accepted on a rising clock
// edge where waitrequest is low; until then the master keeps the request and
// its address/data/byteenable stable. Read data returns later (or in the
// accepting cycle) qualified by a single-cycle readdatavalid.
// ----------------------------------------------------------------------------
interface f2h_tester_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
) ();
   logic                  write;
   logic                  read;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     writedata;
   logic                  readdatavalid;
   logic [DATA_W-1:0]     readdata;
   logic                  waitrequest;

   modport master (
      output write, read, address, byteenable, writedata,
      input  readdatavalid, readdata, waitrequest
   );

   modport slave (
      input  write, read, address, byteenable, writedata,
      output readdatavalid, readdata, waitrequest
   );
endinterface

// File: rtl/f2h_tester_csr.sv
// ----------------------------------------------------------------------------
// f2h_tester_csr
// CSR register file and readback mux for the F2H interface tester.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   write/read/address/writedata : Avalon-MM CSR slave request
//   readdatavalid/readdata: registered read response (1 cycle after read)
//   start_wr/start_rd     : decoded CTRL write pulses (write wins over read)
//   addr_lo/addr_hi/wdata : software-owned RW registers
//   status/rdata/wr_cnt/rd_cnt : read-only values owned by the top
// ----------------------------------------------------------------------------
module f2h_tester_csr
   import f2h_tester_pkg::*;
#(
   parameter int CSR_ADDR_W = 14,
   parameter int CSR_DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write,
   input  logic                  read,
   input  logic [CSR_ADDR_W-1:0] address,
   input  logic [CSR_DATA_W-1:0] writedata,
   output logic                  readdatavalid,
   output logic [CSR_DATA_W-1:0] readdata,
   output logic                  start_wr,
   output logic                  start_rd,
   output logic [31:0]           addr_lo,
   output logic [31:0]           addr_hi,
   output logic [31:0]           wdata,
   input  logic [31:0]           status,
   input  logic [31:0]           rdata,
   input  logic [31:0]           wr_cnt,
   input  logic [31:0]           rd_cnt
);

   logic [5:0]  offset;
   logic        ctrl_wr;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   assign offset           = address[5:0];
   assign unused_addr_bits = ^address[CSR_ADDR_W-1:6];

   // Start pulses; the top only honours them while idle.
   assign ctrl_wr  = write && (offset == CSR_CTRL);
   assign start_wr = ctrl_wr && writedata[0];
   assign start_rd = ctrl_wr && writedata[1] && !writedata[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_lo <= '0;
         addr_hi <= '0;
         wdata   <= '0;
      end else if (write) begin
         case (offset)
            CSR_ADDR_LO: addr_lo <= writedata[31:0];
            CSR_WDATA:   wdata   <= writedata[31:0];
            CSR_ADDR_HI: addr_hi <= writedata[31:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (offset)
         CSR_ADDR_LO: rd_mux = addr_lo;
         CSR_WDATA:   rd_mux = wdata;
         CSR_ADDR_HI: rd_mux = addr_hi;
         CSR_STATUS:  rd_mux = status;
         CSR_RDATA:   rd_mux = rdata;
         CSR_WR_CNT:  rd_mux = wr_cnt;
         CSR_RD_CNT:  rd_mux = rd_cnt;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readdatavalid <= 1'b0;
         readdata      <= '0;
      end else begin
         readdatavalid <= read;
         readdata      <= read ? rd_mux : '0;
      end
   end

endmodule

// File: rtl/f2h_interface_tester.sv
// ----------------------------------------------------------------------------
// f2h_interface_tester
// CSR-programmed generator of single 32-bit write/read transactions on a
// 512-bit Avalon-MM F2H master port.
// Ports:
//   clk, rst_n     : sole clock, async active-low reset
//   csr_avmm_*     : 32-bit Avalon-MM CSR slave (waitrequest tied low)
//   f2h_avmm       : F2H master bus (f2h_tester_if.master), all outputs
//                    registered
//   dbg_state      : current FSM state for observation
// Build option: define F2H_TESTER_TIMEOUT_EN to abort a transaction that has
// not completed within TIMEOUT_CYC cycles and flag STATUS.timeout.
// ----------------------------------------------------------------------------
module f2h_interface_tester
   import f2h_tester_pkg::*;
#(
   parameter int CSR_ADDR_W  = 14,
   parameter int CSR_DATA_W  = 32,
   parameter int F2H_DATA_W  = 512,
   parameter int F2H_ADDR_W  = 64,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csr_avmm_write,
   input  logic                  csr_avmm_read,
   input  logic [CSR_ADDR_W-1:0] csr_avmm_address,
   input  logic [CSR_DATA_W-1:0] csr_avmm_writedata,
   output logic                  csr_avmm_readdatavalid,
   output logic [CSR_DATA_W-1:0] csr_avmm_readdata,
   output logic                  csr_avmm_waitrequest,
   f2h_tester_if.master          f2h_avmm,
   output state_t                dbg_state
);

   state_t      state;
   logic        start_wr, start_rd;
   logic [31:0] addr_lo, addr_hi, wdata;
   logic [31:0] rdata, wr_cnt, rd_cnt, status;
   logic        wr_done, rd_done, timeout_flag;
   logic [3:0]  lane_q;

   logic [63:0]             addr_full;
   logic [63:0]             addr_aligned;
   logic [3:0]              lane;
   logic [F2H_DATA_W/8-1:0] be_next;
   logic                    unused_addr_bits;

   assign csr_avmm_waitrequest = 1'b0;
   assign dbg_state            = state;

   f2h_tester_csr #(
      .CSR_ADDR_W (CSR_ADDR_W),
      .CSR_DATA_W (CSR_DATA_W)
   ) u_csr (
      .clk           (clk),
      .rst_n         (rst_n),
      .write         (csr_avmm_write),
      .read          (csr_avmm_read),
      .address       (csr_avmm_address),
      .writedata     (csr_avmm_writedata),
      .readdatavalid (csr_avmm_readdatavalid),
      .readdata      (csr_avmm_readdata),
      .start_wr      (start_wr),
      .start_rd      (start_rd),
      .addr_lo       (addr_lo),
      .addr_hi       (addr_hi),
      .wdata         (wdata),
      .status        (status),
      .rdata         (rdata),
      .wr_cnt        (wr_cnt),
      .rd_cnt        (rd_cnt)
   );

   // Lane selection: bits [5:2] pick the 32-bit word inside the 64-byte beat,
   // bits [1:0] are below word granularity and have no effect.
   assign addr_full        = {addr_hi, addr_lo};
   assign addr_aligned     = {addr_full[63:6], 6'b0};
   assign lane             = addr_full[5:2];
   assign unused_addr_bits = ^addr_full[1:0];

   always_comb begin
      be_next = '0;
      be_next[lane_lsb(lane) +: 4] = 4'hF;
   end

   assign status = {28'b0, timeout_flag, rd_done, wr_done, (state != ST_IDLE)};

`ifdef F2H_TESTER_TIMEOUT_EN
   logic [31:0] tcnt;
   logic        timeout_q;
   logic        expired;

   assign timeout_flag = timeout_q;
   assign expired      = (tcnt == 32'(TIMEOUT_CYC - 1));
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= ST_IDLE;
         f2h_avmm.write      <= 1'b0;
         f2h_avmm.read       <= 1'b0;
         f2h_avmm.address    <= '0;
         f2h_avmm.byteenable <= '0;
         f2h_avmm.writedata  <= '0;
         lane_q              <= '0;
         rdata               <= '0;
         wr_cnt              <= '0;
         rd_cnt              <= '0;
         wr_done             <= 1'b0;
         rd_done             <= 1'b0;
`ifdef F2H_TESTER_TIMEOUT_EN
         tcnt                <= '0;
         timeout_q           <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               // Bus fields are latched at start so later CSR writes cannot
               // disturb a request that is already on the bus.
               if (start_wr || start_rd) begin
                  f2h_avmm.address    <= addr_aligned[F2H_ADDR_W-1:0];
                  f2h_avmm.byteenable <= be_next;
                  f2h_avmm.writedata  <= {(F2H_DATA_W/32){wdata}};
                  lane_q              <= lane;
                  wr_done             <= 1'b0;
                  rd_done             <= 1'b0;
`ifdef F2H_TESTER_TIMEOUT_EN
                  tcnt                <= '0;
                  timeout_q           <= 1'b0;
`endif
                  if (start_wr) begin
                     f2h_avmm.write <= 1'b1;
                     state          <= ST_WR_REQ;
                  end else begin
                     f2h_avmm.read  <= 1'b1;
                     state          <= ST_RD_REQ;
                  end
               end
            end

            ST_WR_REQ: begin
               if (!f2h_avmm.waitrequest) begin
                  f2h_avmm.write <= 1'b0;
                  wr_done        <= 1'b1;
                  wr_cnt         <= wr_cnt + 32'd1;
                  state          <= ST_IDLE;
`ifdef F2H_TESTER_TIMEOUT_EN
               end else if (expired) begin
                  f2h_avmm.write <= 1'b0;
                  timeout_q      <= 1'b1;
                  state          <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 32'd1;
`endif
               end
            end

            ST_RD_REQ: begin
               if (!f2h_avmm.waitrequest) begin
                  f2h_avmm.read <= 1'b0;
                  // Response may arrive in the very cycle the read is accepted.
                  if (f2h_avmm.readdatavalid) begin
                     rdata   <= f2h_avmm.readdata[{lane_q, 5'b0} +: 32];
                     rd_done <= 1'b1;
                     rd_cnt  <= rd_cnt + 32'd1;
                     state   <= ST_IDLE;
                  end else begin
                     state   <= ST_RD_WAIT;
`ifdef F2H_TESTER_TIMEOUT_EN
                     tcnt    <= tcnt + 32'd1;
`endif
                  end
`ifdef F2H_TESTER_TIMEOUT_EN
               end else if (expired) begin
                  f2h_avmm.read <= 1'b0;
                  timeout_q     <= 1'b1;
                  state         <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 32'd1;
`endif
               end
            end

            ST_RD_WAIT: begin
               if (f2h_avmm.readdatavalid) begin
                  rdata   <= f2h_avmm.readdata[{lane_q, 5'b0} +: 32];
                  rd_done <= 1'b1;
                  rd_cnt  <= rd_cnt + 32'd1;
                  state   <= ST_IDLE;
`ifdef F2H_TESTER_TIMEOUT_EN
               end else if (expired) begin
                  timeout_q <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 32'd1;
`endif
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_f2h_interface_tester.sv
// ----------------------------------------------------------------------------
// tb_f2h_interface_tester
// Directed bench for f2h_interface_tester. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_f2h_interface_tester;
   import f2h_tester_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        csr_write, csr_read;
   logic [13:0] csr_address;
   logic [31:0] csr_writedata;
   logic        csr_rdv;
   logic [31:0] csr_readdata;
   logic        csr_wait;
   state_t      dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   f2h_tester_if #(.ADDR_W(64), .DATA_W(512)) f2h_bus ();

   f2h_interface_tester #(
      .CSR_ADDR_W  (14),
      .CSR_DATA_W  (32),
      .F2H_DATA_W  (512),
      .F2H_ADDR_W  (64),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .csr_avmm_write         (csr_write),
      .csr_avmm_read          (csr_read),
      .csr_avmm_address       (csr_address),
      .csr_avmm_writedata     (csr_writedata),
      .csr_avmm_readdatavalid (csr_rdv),
      .csr_avmm_readdata      (csr_readdata),
      .csr_avmm_waitrequest   (csr_wait),
      .f2h_avmm               (f2h_bus),
      .dbg_state              (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers (called right after a falling edge) ----------------
   task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
      csr_write     = 1'b1;
      csr_address   = a;
      csr_writedata = d;
      @(negedge clk);
      csr_write     = 1'b0;
   endtask

   task automatic csr_rd_check(input string tag, input logic [13:0] a, input logic [31:0] exp);
      csr_read    = 1'b1;
      csr_address = a;
      @(negedge clk);
      csr_read    = 1'b0;
      check({tag, "_rdv"}, 512'(csr_rdv), 512'(1'b1));
      check(tag, 512'(csr_readdata), 512'(exp));
   endtask

   logic [511:0] be_exp;
   int           hi_cycles;

   initial begin
      rst_n                 = 1'b0;
      csr_write             = 1'b0;
      csr_read              = 1'b0;
      csr_address           = '0;
      csr_writedata         = '0;
      f2h_bus.waitrequest   = 1'b0;
      f2h_bus.readdatavalid = 1'b0;
      f2h_bus.readdata      = '0;

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_write",  512'(f2h_bus.write), 512'(0));
      check("rst_read",   512'(f2h_bus.read), 512'(0));
      check("rst_addr",   512'(f2h_bus.address), 512'(0));
      check("rst_be",     512'(f2h_bus.byteenable), 512'(0));
      check("rst_wdata",  f2h_bus.writedata, 512'(0));
      check("rst_csrrdv", 512'(csr_rdv), 512'(0));
      check("rst_csrrd",  512'(csr_readdata), 512'(0));
      check("rst_wait",   512'(csr_wait), 512'(0));
      check("rst_state",  512'(dbg_state), 512'(ST_IDLE));
      for (int i = 0; i < 8; i++)
         csr_rd_check($sformatf("rst_csr%0d", i), 14'(i * 4), 32'h0);

      // ---------------- write transaction ----------------
      csr_wr(14'h08, 32'hDEAFDEAD);
      csr_wr(14'h04, 32'hFFFF0C64);
      f2h_bus.waitrequest = 1'b1;
      csr_write     = 1'b1;
      csr_address   = 14'h00;
      csr_writedata = 32'h1;
      @(negedge clk);
      be_exp = 512'h0;
      be_exp[39:36] = 4'hF;
      check("wr_write",  512'(f2h_bus.write), 512'(1));
      check("wr_addr",   512'(f2h_bus.address), 512'(64'h00000000FFFF0C40));
      check("wr_be",     512'(f2h_bus.byteenable), be_exp);
      check("wr_wdata",  f2h_bus.writedata, {16{32'hDEAFDEAD}});
      check("wr_state",  512'(dbg_state), 512'(ST_WR_REQ));
      @(negedge clk);
      csr_write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("wr_hold", 512'(f2h_bus.write), 512'(1));
      end
      check("wr_hold_addr", 512'(f2h_bus.address), 512'(64'h00000000FFFF0C40));
      csr_rd_check("wr_busy_status", 14'h10, 32'h1);
      f2h_bus.waitrequest = 1'b0;
      check("wr_last_cycle", 512'(f2h_bus.write), 512'(1));
      @(negedge clk);
      check("wr_drop",       512'(f2h_bus.write), 512'(0));
      check("wr_idle",       512'(dbg_state), 512'(ST_IDLE));
      csr_rd_check("wr_cnt1",    14'h18, 32'h1);
      csr_rd_check("wr_status",  14'h10, 32'h2);
      csr_rd_check("wr_rdcnt0",  14'h1C, 32'h0);

      // ---------------- read transaction ----------------
      csr_wr(14'h04, 32'hFFFF0984);
      f2h_bus.readdata          = '0;
      f2h_bus.readdata[31:0]    = 32'hABABABAB;
      f2h_bus.readdata[63:32]   = 32'hCDCD0505;
      f2h_bus.readdata[95:64]   = 32'hDEADDEAD;
      csr_wr(14'h00, 32'h2);
      check("rd_read",   512'(f2h_bus.read), 512'(1));
      check("rd_write0", 512'(f2h_bus.write), 512'(0));
      check("rd_addr",   512'(f2h_bus.address), 512'(64'h00000000FFFF0980));
      check("rd_be",     512'(f2h_bus.byteenable), 512'(64'h00000000000000F0));
      @(negedge clk);
      check("rd_accept", 512'(f2h_bus.read), 512'(0));
      check("rd_wait",   512'(dbg_state), 512'(ST_RD_WAIT));
      @(negedge clk);
      check("rd_wait2",  512'(dbg_state), 512'(ST_RD_WAIT));
      f2h_bus.readdatavalid = 1'b1;
      @(negedge clk);
      f2h_bus.readdatavalid = 1'b0;
      check("rd_idle",   512'(dbg_state), 512'(ST_IDLE));
      csr_rd_check("rd_rdata",  14'h14, 32'hCDCD0505);
      csr_rd_check("rd_cnt1",   14'h1C, 32'h1);
      csr_rd_check("rd_status", 14'h10, 32'h4);

      // readdatavalid while idle must be ignored
      f2h_bus.readdata[63:32] = 32'h11111111;
      f2h_bus.readdatavalid   = 1'b1;
      @(negedge clk);
      f2h_bus.readdatavalid   = 1'b0;
      csr_rd_check("idle_rdv_rdata", 14'h14, 32'hCDCD0505);
      csr_rd_check("idle_rdv_cnt",   14'h1C, 32'h1);

      // read accepted and answered in the same cycle, with ADDR_HI set
      csr_wr(14'h0C, 32'h00000001);
      csr_wr(14'h04, 32'hFFFF0988);
      csr_wr(14'h00, 32'h2);
      check("rd2_addr", 512'(f2h_bus.address), 512'(64'h00000001FFFF0980));
      f2h_bus.readdatavalid = 1'b1;
      @(negedge clk);
      f2h_bus.readdatavalid = 1'b0;
      check("rd2_idle", 512'(dbg_state), 512'(ST_IDLE));
      check("rd2_read", 512'(f2h_bus.read), 512'(0));
      csr_rd_check("rd2_rdata", 14'h14, 32'hDEADDEAD);
      csr_rd_check("rd2_cnt",   14'h1C, 32'h2);

      // ---------------- CTRL ignored while busy ----------------
      csr_wr(14'h0C, 32'h0);
      f2h_bus.waitrequest = 1'b1;
      csr_wr(14'h00, 32'h1);
      csr_wr(14'h00, 32'h2);
      check("busy_write", 512'(f2h_bus.write), 512'(1));
      check("busy_state", 512'(dbg_state), 512'(ST_WR_REQ));
      f2h_bus.waitrequest = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_noread", 512'(f2h_bus.read), 512'(0));
      check("busy_idle",   512'(dbg_state), 512'(ST_IDLE));
      csr_rd_check("busy_rdcnt",  14'h1C, 32'h2);
      csr_rd_check("busy_wrcnt",  14'h18, 32'h2);
      csr_rd_check("busy_status", 14'h10, 32'h2);

      // ---------------- both CTRL bits: write wins ----------------
      csr_wr(14'h00, 32'h3);
      check("both_write", 512'(f2h_bus.write), 512'(1));
      check("both_read",  512'(f2h_bus.read), 512'(0));
      @(negedge clk);
      csr_rd_check("both_wrcnt", 14'h18, 32'h3);
      csr_rd_check("both_rdcnt", 14'h1C, 32'h2);

      // ---------------- unmapped / CTRL readback ----------------
      csr_wr(14'h20, 32'h55);
      csr_rd_check("unmapped", 14'h20, 32'h0);
      csr_rd_check("ctrl_rd",  14'h00, 32'h0);
      csr_rd_check("wdata_rd", 14'h08, 32'hDEAFDEAD);

`ifdef F2H_TESTER_TIMEOUT_EN
      // ---------------- timeout ----------------
      f2h_bus.waitrequest = 1'b1;
      csr_wr(14'h00, 32'h1);
      hi_cycles = 0;
      while (f2h_bus.write && hi_cycles < 100) begin
         hi_cycles++;
         @(negedge clk);
      end
      check("to_cycles", 512'(hi_cycles), 512'(16));
      check("to_idle",   512'(dbg_state), 512'(ST_IDLE));
      csr_rd_check("to_status", 14'h10, 32'h8);
      csr_rd_check("to_wrcnt",  14'h18, 32'h3);
      f2h_bus.waitrequest = 1'b0;
`endif

      // ---------------- mid-operation reset ----------------
      f2h_bus.waitrequest = 1'b1;
      csr_wr(14'h00, 32'h2);
      check("mr_read_before", 512'(f2h_bus.read), 512'(1));
      #2 rst_n = 1'b0;
      #1;
      check("mr_read",  512'(f2h_bus.read), 512'(0));
      check("mr_addr",  512'(f2h_bus.address), 512'(0));
      check("mr_be",    512'(f2h_bus.byteenable), 512'(0));
      check("mr_wdata", f2h_bus.writedata, 512'(0));
      check("mr_state", 512'(dbg_state), 512'(ST_IDLE));
      f2h_bus.waitrequest = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      csr_rd_check("mr_wrcnt",  14'h18, 32'h0);
      csr_rd_check("mr_rdcnt",  14'h1C, 32'h0);
      csr_rd_check("mr_status", 14'h10, 32'h0);
      csr_rd_check("mr_addrlo", 14'h04, 32'h0);
      csr_rd_check("mr_wdata",  14'h08, 32'h0);
      csr_rd_check("mr_rdata",  14'h14, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
